// File: rtl/bcd_to_hex_points_if.sv
// ============================================================================
//  Module   : bcd_to_hex_points_if
//  Purpose  : Start/busy/done handshake and digit/result bundle for the
//             sequential BCD-to-binary points converter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_to_hex_points_if #(
    parameter int WIDTH = 20
);
    logic             iStart;
    logic [3:0]       iDigit1;
    logic [3:0]       iDigit2;
    logic [3:0]       iDigit3;
    logic [3:0]       iDigit4;
    logic [3:0]       iDigit5;
    logic [3:0]       iDigit6;
    logic [WIDTH-1:0] oHexPoints;
    logic             oBusy;
    logic             oDone;
    logic             oError;

    modport master (
        output iStart, iDigit1, iDigit2, iDigit3, iDigit4, iDigit5, iDigit6,
        input  oHexPoints, oBusy, oDone, oError
    );

    modport slave (
        input  iStart, iDigit1, iDigit2, iDigit3, iDigit4, iDigit5, iDigit6,
        output oHexPoints, oBusy, oDone, oError
    );
endinterface

`default_nettype wire

// File: rtl/bcd_to_hex_points.sv
// ============================================================================
//  Module   : bcd_to_hex_points
//  Purpose  : Converts six BCD digits to a binary points value, one digit per
//             clock (acc = acc*10 + d), flagging any digit above 9.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_hex_points #(
    parameter int NUM_DIGITS = 6,
    parameter int WIDTH      = 20
) (
    input  wire logic           iClk,
    input  wire logic           iRst_n,
    bcd_to_hex_points_if.slave  bus
);

    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SR_W  = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           rState;
    state_t           wStateNext;
    logic [SR_W-1:0]  rShift;
    logic [WIDTH-1:0] rAcc;
    logic [CNT_W-1:0] rCount;
    logic             rBad;
    logic [WIDTH-1:0] rHexPoints;
    logic             rError;

    logic [3:0]       wDigitArr [6];
    logic [SR_W-1:0]  wLoadVec;
    logic [3:0]       wCurDigit;
    logic [WIDTH-1:0] wAccNext;
    logic             wBadNext;
    logic             wStart;
    logic             wLast;

    assign wDigitArr[0] = bus.iDigit1;
    assign wDigitArr[1] = bus.iDigit2;
    assign wDigitArr[2] = bus.iDigit3;
    assign wDigitArr[3] = bus.iDigit4;
    assign wDigitArr[4] = bus.iDigit5;
    assign wDigitArr[5] = bus.iDigit6;

    // Most significant digit lands in the top nibble so it is consumed first.
    always_comb begin
        wLoadVec = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            wLoadVec[4*i +: 4] = wDigitArr[i];
        end
    end

    assign wCurDigit = rShift[SR_W-1 -: 4];
    assign wAccNext  = (rAcc << 3) + (rAcc << 1) + {{(WIDTH-4){1'b0}}, wCurDigit};
    assign wBadNext  = rBad | (wCurDigit > 4'd9);
    assign wStart    = (rState != ACCUM) && bus.iStart;
    assign wLast     = (rState == ACCUM) && (rCount == C_LAST_CNT);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rState <= IDLE;
        end else begin
            rState <= wStateNext;
        end
    end

    always_comb begin
        wStateNext = rState;
        case (rState)
            IDLE:    if (bus.iStart) wStateNext = ACCUM;
            ACCUM:   if (wLast)      wStateNext = DONE;
            DONE:    wStateNext = bus.iStart ? ACCUM : IDLE;
            default: wStateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rShift     <= '0;
            rAcc       <= '0;
            rCount     <= '0;
            rBad       <= 1'b0;
            rHexPoints <= '0;
            rError     <= 1'b0;
        end else if (wStart) begin
            rShift <= wLoadVec;
            rAcc   <= '0;
            rCount <= '0;
            rBad   <= 1'b0;
        end else if (rState == ACCUM) begin
            rShift <= {rShift[SR_W-5:0], 4'b0000};
            rAcc   <= wAccNext;
            rBad   <= wBadNext;
            rCount <= rCount + CNT_W'(1);
            // A bad digit invalidates the whole value, so publish zero instead.
            if (wLast) begin
                rHexPoints <= wBadNext ? '0 : wAccNext;
                rError     <= wBadNext;
            end
        end
    end

    assign bus.oHexPoints = rHexPoints;
    assign bus.oError     = rError;
    assign bus.oBusy      = (rState == ACCUM);
    assign bus.oDone      = (rState == DONE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_hex_points.sv
// ============================================================================
//  Module   : tb_bcd_to_hex_points
//  Purpose  : Directed self-checking bench for bcd_to_hex_points.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_hex_points;

    localparam int WIDTH = 20;

    logic clk;
    logic rstN;
    int   vecCnt;
    int   errCnt;
    logic [WIDTH-1:0] lastHex;
    logic             lastErr;

    bcd_to_hex_points_if #(.WIDTH(WIDTH)) bus ();

    bcd_to_hex_points #(.NUM_DIGITS(6), .WIDTH(WIDTH)) dut (
        .iClk   (clk),
        .iRst_n (rstN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setDigits(input logic [3:0] d6, d5, d4, d3, d2, d1);
        bus.iDigit6 = d6; bus.iDigit5 = d5; bus.iDigit4 = d4;
        bus.iDigit3 = d3; bus.iDigit2 = d2; bus.iDigit1 = d1;
    endtask

    // Entered on a falling edge; digits given MSB first.
    task automatic convert(input logic [3:0] d6, d5, d4, d3, d2, d1,
                           input logic [WIDTH-1:0] expHex, input logic expErr,
                           input bit changeMid);
        setDigits(d6, d5, d4, d3, d2, d1);
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        chk("busyAfterE0", 32'(bus.oBusy), 32'd1);
        chk("doneAfterE0", 32'(bus.oDone), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("busyAccum", 32'(bus.oBusy), 32'd1);
            chk("doneAccum", 32'(bus.oDone), 32'd0);
            if (k == 2 && changeMid) begin
                setDigits(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4);
                bus.iStart = 1'b1;
            end
            if (k == 3) begin
                bus.iStart = 1'b0;
                chk("hexHeldAccum", 32'(bus.oHexPoints), 32'(lastHex));
                chk("errHeldAccum", 32'(bus.oError), 32'(lastErr));
            end
        end
        @(negedge clk);
        chk("doneAtE6", 32'(bus.oDone), 32'd1);
        chk("busyAtE6", 32'(bus.oBusy), 32'd0);
        chk("hexResult", 32'(bus.oHexPoints), 32'(expHex));
        chk("errResult", 32'(bus.oError), 32'(expErr));
        lastHex = expHex;
        lastErr = expErr;
        @(negedge clk);
        chk("donePulse", 32'(bus.oDone), 32'd0);
        chk("hexHeldIdle", 32'(bus.oHexPoints), 32'(lastHex));
    endtask

    initial begin
        bit sawDone;
        vecCnt = 0;
        errCnt = 0;
        lastHex = '0;
        lastErr = 1'b0;
        rstN = 1'b0;
        bus.iStart = 1'b0;
        setDigits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        repeat (2) @(negedge clk);
        chk("rstHex", 32'(bus.oHexPoints), 32'd0);
        chk("rstBusy", 32'(bus.oBusy), 32'd0);
        chk("rstDone", 32'(bus.oDone), 32'd0);
        chk("rstErr", 32'(bus.oError), 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        convert(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 20'h00000, 1'b0, 1'b0);
        convert(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 20'hF423F, 1'b0, 1'b0);
        convert(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 20'h03039, 1'b0, 1'b1);
        convert(4'd0, 4'd0, 4'd0, 4'hA, 4'd0, 4'd0, 20'h00000, 1'b1, 1'b0);
        convert(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 20'h00007, 1'b0, 1'b0);

        // Start held high: the done cycle accepts the next start, so a new
        // result arrives every seven edges.
        setDigits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        bus.iStart = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            chk("heldDone", 32'(bus.oDone), 32'((k % 7) == 0));
            chk("heldBusy", 32'(bus.oBusy), 32'((k % 7) != 0));
            if ((k % 7) == 0) begin
                chk("heldHex", 32'(bus.oHexPoints), 32'h1E240);
            end
        end
        bus.iStart = 1'b0;
        @(negedge clk);
        chk("heldToIdle", 32'(bus.oBusy), 32'd0);

        // Asynchronous reset in the middle of a conversion.
        setDigits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("midRstHex", 32'(bus.oHexPoints), 32'd0);
        chk("midRstBusy", 32'(bus.oBusy), 32'd0);
        chk("midRstDone", 32'(bus.oDone), 32'd0);
        chk("midRstErr", 32'(bus.oError), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.oDone || bus.oBusy) sawDone = 1'b1;
        end
        chk("noDoneAfterRst", 32'(sawDone), 32'd0);
        lastHex = '0;
        lastErr = 1'b0;
        convert(4'd0, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 20'h0D431, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

`default_nettype wire
